instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 38 +++
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 tb/tb_instr_encoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/write bus between an instruction-load master and instr_encoder.
// The slave side accepts encode requests and emits instruction-memory writes.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        op_sel;
  logic [3:0]        cond;
  logic              set_s;
  logic              use_imm;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [3:0]        rs;
  logic [23:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              full;
  logic              err;

  modport master (
    output start, in_valid, in_last, op_sel, cond, set_s, use_imm,
           rd, rn, rm, rs, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err
  );

  modport slave (
    input  start, in_valid, in_last, op_sel, cond, set_s, use_imm,
           rd, rn, rm, rs, imm,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes ARM-style instruction requests into 32-bit words and streams them
// into an instruction memory at consecutive word addresses, one per cycle.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_CMP  = 4'd4,
    OP_MOV  = 4'd5,
    OP_MOVW = 4'd6,
    OP_MUL  = 4'd7,
    OP_LDR  = 4'd8,
    OP_STR  = 4'd9,
    OP_B    = 4'd10
  } op_t;

  localparam logic [31:0]       NOP_WORD  = 32'hE1A0_0000;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              full_q;
  logic              err_q;

  op_t         op;
  logic        accept;
  logic        at_last;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic [3:0]  dp_cmd;
  logic        dp_s;
  logic [3:0]  dp_rn;
  logic [3:0]  dp_rd;
  logic [11:0] dp_op2;

  assign op      = op_t'(bus.op_sel);
  // start has priority over a request presented in the same cycle
  assign accept  = bus.in_valid && (state == LOAD) && !bus.start;
  assign at_last = (addr == ADDR_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    enc_word = NOP_WORD;
    enc_bad  = 1'b0;
    dp_cmd   = 4'b0000;
    dp_s     = bus.set_s;
    dp_rn    = bus.rn;
    dp_rd    = bus.rd;
    dp_op2   = bus.use_imm ? {4'h0, bus.imm[7:0]} : {8'h00, bus.rm};

    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CMP, OP_MOV: begin
        case (op)
          OP_ADD:  dp_cmd = 4'b0100;
          OP_SUB:  dp_cmd = 4'b0010;
          OP_AND:  dp_cmd = 4'b0000;
          OP_ORR:  dp_cmd = 4'b1100;
          OP_CMP: begin
            dp_cmd = 4'b1010;
            dp_s   = 1'b1;
            dp_rd  = 4'h0;
          end
          OP_MOV: begin
            dp_cmd = 4'b1101;
            dp_rn  = 4'h0;
          end
          default: dp_cmd = 4'b0000;
        endcase
        enc_word = {bus.cond, 2'b00, bus.use_imm, dp_cmd, dp_s, dp_rn, dp_rd, dp_op2};
        enc_bad  = bus.use_imm && (bus.imm > 24'd255);
      end
      OP_MOVW: begin
        enc_word = {bus.cond, 8'b0011_0000, bus.imm[15:12], bus.rd, bus.imm[11:0]};
        enc_bad  = (bus.imm > 24'd65535);
      end
      OP_MUL: begin
        enc_word = {bus.cond, 7'b0000000, bus.set_s, 4'h0, bus.rd, bus.rs, 4'b1001, bus.rm};
      end
      OP_LDR, OP_STR: begin
        enc_word = {bus.cond, 2'b01, 5'b01100, (op == OP_LDR), bus.rn, bus.rd, bus.imm[11:0]};
        enc_bad  = (bus.imm > 24'd4095);
      end
      OP_B: begin
        enc_word = {bus.cond, 4'b1010, bus.imm};
      end
      default: enc_bad = 1'b1;
    endcase

    if (enc_bad) enc_word = NOP_WORD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= accept;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= enc_word;
      end

      if (bus.start) begin
        // A new session starts at address 0, so the saturation flag goes too.
        state  <= LOAD;
        addr   <= '0;
        err_q  <= 1'b0;
        full_q <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          LOAD: begin
            if (accept) begin
              if (enc_bad) err_q <= 1'b1;
              if (at_last) full_q <= 1'b1;
              else         addr   <= addr + ADDR_W'(1);
              if (bus.in_last || at_last) state <= DONE;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = (state == LOAD);
  assign bus.busy       = (state == LOAD);
  assign bus.done       = (state == DONE);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized
// sessions compared against a field-arithmetic reference encoder.
module tb_instr_encoder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) bus8 ();
  instr_encoder_if #(.ADDR_W(2)) bus2 ();

  instr_encoder #(.ADDR_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  instr_encoder #(.ADDR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model of dut8
  bit          m_load, m_done, m_err, m_full;
  int          m_addr;
  bit          e_we;
  int          e_addr;
  logic [31:0] e_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Builds the word by weighting each field with its bit position.
  function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [3:0] cond,
                                           input logic s, input logic ui,
                                           input logic [3:0] rd, input logic [3:0] rn,
                                           input logic [3:0] rm, input logic [3:0] rs,
                                           input logic [23:0] imm, output bit bad);
    longint w, c, lrd, lrn, lrm, lrs, li, ls, cmd, op2;
    w = 0; bad = 1'b0;
    c = longint'(cond); lrd = longint'(rd); lrn = longint'(rn);
    lrm = longint'(rm); lrs = longint'(rs); li = longint'(imm); ls = longint'(s);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        case (op)
          4'd0: cmd = 4;  4'd1: cmd = 2;  4'd2: cmd = 0;
          4'd3: cmd = 12; 4'd4: cmd = 10; default: cmd = 13;
        endcase
        if (op == 4'd4) begin ls = 1; lrd = 0; end
        if (op == 4'd5) lrn = 0;
        op2 = ui ? li % 256 : lrm;
        w = c * 2**28 + (ui ? 1 : 0) * 2**25 + cmd * 2**21 + ls * 2**20
          + lrn * 2**16 + lrd * 2**12 + op2;
        bad = ui && (li > 255);
      end
      4'd6: begin
        w = c * 2**28 + 'h30 * 2**20 + ((li / 4096) % 16) * 2**16 + lrd * 2**12 + li % 4096;
        bad = (li > 65535);
      end
      4'd7: w = c * 2**28 + ls * 2**20 + lrd * 4096 + lrs * 256 + 9 * 16 + lrm;
      4'd8, 4'd9: begin
        w = c * 2**28 + 2**26 + 12 * 2**21 + ((op == 4'd8) ? 1 : 0) * 2**20
          + lrn * 2**16 + lrd * 2**12 + li % 4096;
        bad = (li > 4095);
      end
      4'd10: w = c * 2**28 + 10 * 2**24 + li;
      default: bad = 1'b1;
    endcase
    if (bad) w = 'hE1A00000;
    return w[31:0];
  endfunction

  task automatic set_req(input int op, input int cond, input bit s, input bit ui,
                         input int rd, input int rn, input int rm, input int rs,
                         input int imm, input bit last);
    bus8.in_valid = 1'b1;
    bus8.op_sel   = 4'(op);
    bus8.cond     = 4'(cond);
    bus8.set_s    = s;
    bus8.use_imm  = ui;
    bus8.rd       = 4'(rd);
    bus8.rn       = 4'(rn);
    bus8.rm       = 4'(rm);
    bus8.rs       = 4'(rs);
    bus8.imm      = 24'(imm);
    bus8.in_last  = last;
  endtask

  // Advances dut8 one clock with the inputs already set, then compares at the falling edge.
  task automatic cycle8();
    bit bad;
    if (bus8.start) begin
      m_load = 1; m_done = 0; m_addr = 0; m_err = 0; m_full = 0; e_we = 0;
    end else if (bus8.in_valid && m_load) begin
      e_we   = 1;
      e_addr = m_addr;
      e_data = ref_word(bus8.op_sel, bus8.cond, bus8.set_s, bus8.use_imm, bus8.rd,
                        bus8.rn, bus8.rm, bus8.rs, bus8.imm, bad);
      if (bad) m_err = 1;
      if (m_addr == 255) m_full = 1;
      if (bus8.in_last || m_addr == 255) begin m_load = 0; m_done = 1; end
      if (m_addr < 255) m_addr++;
    end else begin
      e_we = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("imem_we", 32'(bus8.imem_we), 32'(e_we));
    if (e_we) begin
      check("imem_addr", 32'(bus8.imem_addr), 32'(e_addr));
      check("imem_wdata", bus8.imem_wdata, e_data);
    end
    check("in_ready", 32'(bus8.in_ready), 32'(m_load));
    check("busy", 32'(bus8.busy), 32'(m_load));
    check("done", 32'(bus8.done), 32'(m_done));
    check("err", 32'(bus8.err), 32'(m_err));
    check("full", 32'(bus8.full), 32'(m_full));
    bus8.start    = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
  endtask

  task automatic check_all_zero8(input string tag);
    check({tag, "_we"}, 32'(bus8.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus8.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus8.imem_wdata, 32'd0);
    check({tag, "_flags"}, {27'd0, bus8.in_ready, bus8.busy, bus8.done, bus8.full, bus8.err}, 32'd0);
  endtask

  int imm_edges[8] = '{255, 256, 4095, 4096, 65535, 65536, 0, 24'hFFFFFF};

  initial begin
    int writes, hands, idx, imm_v;
    bit bad;
    logic [31:0] exp_w;

    bus8.start = 0; bus8.in_valid = 0; bus8.in_last = 0; bus8.op_sel = 0; bus8.cond = 0;
    bus8.set_s = 0; bus8.use_imm = 0; bus8.rd = 0; bus8.rn = 0; bus8.rm = 0; bus8.rs = 0;
    bus8.imm = 0;
    bus2.start = 0; bus2.in_valid = 0; bus2.in_last = 0; bus2.op_sel = 0; bus2.cond = 0;
    bus2.set_s = 0; bus2.use_imm = 0; bus2.rd = 0; bus2.rn = 0; bus2.rm = 0; bus2.rs = 0;
    bus2.imm = 0;
    m_load = 0; m_done = 0; m_err = 0; m_full = 0; m_addr = 0; e_we = 0;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check_all_zero8("rst_hold");
    check("rst_hold_dut2", {27'd0, bus2.imem_we, bus2.in_ready, bus2.done, bus2.full, bus2.err}, 32'd0);
    reset = 1'b0;
    cycle8();

    // Single ADD with immediate
    bus8.start = 1; cycle8();
    set_req(0, 14, 0, 1, 1, 2, 0, 0, 5, 0); cycle8();
    check("add_imm_word", bus8.imem_wdata, 32'hE2821005);
    check("add_imm_addr", 32'(bus8.imem_addr), 32'd0);

    // Back-to-back CMP, MUL, LDR ending the session
    bus8.start = 1; cycle8();
    set_req(4, 14, 0, 0, 0, 3, 4, 0, 0, 0); cycle8();
    check("cmp_word", bus8.imem_wdata, 32'hE1530004);
    set_req(7, 14, 0, 0, 5, 0, 7, 6, 0, 0); cycle8();
    check("mul_word", bus8.imem_wdata, 32'hE0005697);
    set_req(8, 14, 0, 0, 1, 2, 0, 0, 8, 1); cycle8();
    check("ldr_word", bus8.imem_wdata, 32'hE5921008);
    check("ldr_addr", 32'(bus8.imem_addr), 32'd2);
    check("session_done", {30'd0, bus8.done, bus8.in_ready}, 32'd2);
    set_req(0, 14, 0, 0, 1, 1, 1, 0, 0, 0); cycle8();   // refused in DONE

    // MOVW, then an illegal op producing NOP and err
    bus8.start = 1; cycle8();
    set_req(6, 14, 0, 0, 2, 0, 0, 0, 'h1234, 0); cycle8();
    check("movw_word", bus8.imem_wdata, 32'hE3012234);
    set_req(12, 14, 0, 0, 2, 0, 0, 0, 0, 0); cycle8();
    check("illegal_word", bus8.imem_wdata, 32'hE1A00000);
    check("illegal_err", 32'(bus8.err), 32'd1);
    check("illegal_addr", 32'(bus8.imem_addr), 32'd1);
    // start together with a request: start wins, err clears
    set_req(0, 14, 0, 0, 1, 1, 1, 0, 0, 0); bus8.start = 1; cycle8();
    check("start_clears_err", 32'(bus8.err), 32'd0);

    // Immediate range boundaries
    set_req(0, 14, 1, 1, 3, 4, 0, 0, 255, 0); cycle8();
    check("imm255_word", bus8.imem_wdata, 32'hE29430FF);
    set_req(0, 14, 1, 1, 3, 4, 0, 0, 256, 0); cycle8();
    check("imm256_err", {31'd0, bus8.err}, 32'd1);

    // Randomized sessions
    for (int i = 0; i < 400; i++) begin
      if (!m_load ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 99) < 3)) bus8.start = 1;
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       imm_v = imm_edges[$urandom_range(0, 7)];
          1:       imm_v = int'($urandom_range(0, 255));
          2:       imm_v = int'($urandom_range(0, 4200));
          default: imm_v = int'($urandom & 32'h00FF_FFFF);
        endcase
        set_req(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                imm_v, $urandom_range(0, 24) == 0);
      end
      cycle8();
    end

    // Reset right after an acceptance discards the pending write
    bus8.start = 1; cycle8();
    set_req(10, 14, 0, 0, 0, 0, 0, 0, 'h123456, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("abort_no_we", 32'(bus8.imem_we), 32'd0);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check_all_zero8("abort_hold");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero8("abort_after");
    m_load = 0; m_done = 0; m_err = 0; m_full = 0; m_addr = 0; e_we = 0;

    // Small memory: five requests offered, four fit
    bus2.start = 1;
    @(negedge clk);
    bus2.start = 0;
    writes = 0; hands = 0; idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus2.imem_we) begin
        exp_w = ref_word(4'd5, 4'd14, 1'b0, 1'b0, 4'(writes), 4'd0, 4'(writes), 4'd0, 24'd0, bad);
        check("small_addr", 32'(bus2.imem_addr), 32'(writes));
        check("small_wdata", bus2.imem_wdata, exp_w);
        writes++;
      end
      bus2.in_valid = (idx < 5);
      bus2.op_sel = 4'd5; bus2.cond = 4'd14; bus2.use_imm = 1'b0;
      bus2.rd = 4'(idx); bus2.rm = 4'(idx);
      if (bus2.in_valid && bus2.in_ready) begin hands++; idx++; end
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    check("small_writes", 32'(writes), 32'd4);
    check("small_accepts", 32'(hands), 32'd4);
    check("small_status", {29'd0, bus2.full, bus2.done, bus2.in_ready}, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
